// File: rtl/fpga_dsp_bus_master.sv
// FPGA-side master for the FPGA-to-DSP strobe bus: parametrised widths,
// programmable setup/strobe/hold timing, incrementing bursts, DSP wait-state
// extension with timeout abort. The data bus is split into out/enable/in.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | bus released (N_CS=1), Ready=1, waiting for Start
// SETUP  | N_CS low, address/direction/data presented, N_DS still high
// STROBE | N_DS low; minimum width, then stretched while N_Wait is low
// HOLD   | N_DS high, N_CS low, bus held; advance to next word or finish
module fpga_dsp_bus_master #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int BURST_W    = 4,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1,
  parameter int WAIT_MAX   = 15
) (
  input  logic              i_Clk,
  input  logic              i_N_Reset,
  input  logic              i_Start,
  output logic              o_Ready,
  input  logic              i_Write,
  input  logic [ADDR_W-1:0] i_Addr,
  input  logic [BURST_W-1:0] i_Len,
  input  logic [DATA_W-1:0] i_WrData,
  output logic              o_WrAdv,
  output logic [DATA_W-1:0] o_RdData,
  output logic              o_RdValid,
  output logic              o_Done,
  output logic              o_Error,
  output logic              o_N_CS,
  output logic              o_N_DS,
  output logic              o_R_NW,
  output logic [ADDR_W-1:0] o_AddrBus,
  output logic [DATA_W-1:0] o_DataOut,
  output logic              o_DataOutEn,
  input  logic [DATA_W-1:0] i_DataIn,
  input  logic              i_N_Wait
);

  // One phase counter serves all three phases, so size it for the longest.
  localparam int PH_MAX = (SETUP_CYC > STROBE_CYC) ?
                          ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                          ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
  localparam int CNT_W  = (PH_MAX < 2) ? 1 : $clog2(PH_MAX);
  localparam int WAIT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

  localparam logic [CNT_W-1:0]  SETUP_LD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0]  STROBE_LD = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0]  HOLD_LD   = CNT_W'(HOLD_CYC - 1);
  localparam logic [WAIT_W-1:0] WAIT_LD   = WAIT_W'(WAIT_MAX);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_STROBE = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [WAIT_W-1:0]   r_wait;
  logic [BURST_W-1:0]  r_words;
  logic                r_write;
  logic                r_n_cs;
  logic                r_n_ds;
  logic                r_r_nw;
  logic                r_data_en;
  logic [ADDR_W-1:0]   r_addr_bus;
  logic [DATA_W-1:0]   r_data_out;
  logic [DATA_W-1:0]   r_rd_data;
  logic                r_rd_valid;
  logic                r_done;
  logic                r_error;

  logic w_accept;
  logic w_ph_last;
  logic w_more;
  logic w_next_word;

  assign w_accept    = (r_state == S_IDLE) && i_Start;
  assign w_ph_last   = (r_cnt == '0);
  assign w_more      = (r_words != '0);
  assign w_next_word = (r_state == S_HOLD) && w_ph_last && w_more;

  // WrAdv must coincide with the edge that latches WrData, so it is decoded
  // from the current state; it is held off while reset is asserted.
  assign o_WrAdv = i_N_Reset && r_write_adv_cond();

  function automatic logic r_write_adv_cond();
    return (w_accept && i_Write) || (w_next_word && r_write);
  endfunction

  assign o_Ready     = (r_state == S_IDLE);
  assign o_RdData    = r_rd_data;
  assign o_RdValid   = r_rd_valid;
  assign o_Done      = r_done;
  assign o_Error     = r_error;
  assign o_N_CS      = r_n_cs;
  assign o_N_DS      = r_n_ds;
  assign o_R_NW      = r_r_nw;
  assign o_AddrBus   = r_addr_bus;
  assign o_DataOut   = r_data_out;
  assign o_DataOutEn = r_data_en;

  // Bus sequencer: phase timing, wait extension, burst advance, registered pins.
  always_ff @(posedge i_Clk) begin
    if (!i_N_Reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_wait     <= '0;
      r_words    <= '0;
      r_write    <= 1'b0;
      r_n_cs     <= 1'b1;
      r_n_ds     <= 1'b1;
      r_r_nw     <= 1'b1;
      r_data_en  <= 1'b0;
      r_addr_bus <= '0;
      r_data_out <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_Start) begin
            r_state    <= S_SETUP;
            r_cnt      <= SETUP_LD;
            r_write    <= i_Write;
            r_words    <= i_Len;
            r_addr_bus <= i_Addr;
            r_n_cs     <= 1'b0;
            r_r_nw     <= ~i_Write;
            r_data_en  <= i_Write;
            if (i_Write) begin
              r_data_out <= i_WrData;
            end
          end
        end
        S_SETUP: begin
          if (w_ph_last) begin
            r_state <= S_STROBE;
            r_cnt   <= STROBE_LD;
            r_wait  <= WAIT_LD;
            r_n_ds  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_STROBE: begin
          if (!w_ph_last) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else if (i_N_Wait) begin
            r_state <= S_HOLD;
            r_cnt   <= HOLD_LD;
            r_n_ds  <= 1'b1;
            if (!r_write) begin
              r_rd_data  <= i_DataIn;
              r_rd_valid <= 1'b1;
            end
          end else if (r_wait == '0) begin
            // Wait budget exhausted: release the bus and drop the rest of the burst.
            r_state   <= S_IDLE;
            r_n_cs    <= 1'b1;
            r_n_ds    <= 1'b1;
            r_r_nw    <= 1'b1;
            r_data_en <= 1'b0;
            r_done    <= 1'b1;
            r_error   <= 1'b1;
          end else begin
            r_wait <= r_wait - WAIT_W'(1);
          end
        end
        S_HOLD: begin
          if (!w_ph_last) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else if (w_more) begin
            r_state    <= S_SETUP;
            r_cnt      <= SETUP_LD;
            r_addr_bus <= r_addr_bus + ADDR_W'(1);
            r_words    <= r_words - BURST_W'(1);
            if (r_write) begin
              r_data_out <= i_WrData;
            end
          end else begin
            r_state   <= S_IDLE;
            r_n_cs    <= 1'b1;
            r_r_nw    <= 1'b1;
            r_data_en <= 1'b0;
            r_done    <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpga_dsp_bus_master.sv
// Bench for fpga_dsp_bus_master: a DSP-side model answers strobes from a
// memory image; expected read/write words are queued when a request is issued
// and compared in order as the DUT produces them.
module tb_fpga_dsp_bus_master;

  logic       clk = 1'b0;
  logic       n_reset;
  logic       start;
  logic       ready;
  logic       write;
  logic [7:0] addr;
  logic [3:0] len;
  logic [7:0] wr_data;
  logic       wr_adv;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       done;
  logic       error;
  logic       n_cs;
  logic       n_ds;
  logic       r_nw;
  logic [7:0] addr_bus;
  logic [7:0] data_out;
  logic       data_en;
  logic [7:0] data_in;
  logic       n_wait;

  always #5 clk = ~clk;

  fpga_dsp_bus_master dut (
    .i_Clk(clk), .i_N_Reset(n_reset), .i_Start(start), .o_Ready(ready),
    .i_Write(write), .i_Addr(addr), .i_Len(len), .i_WrData(wr_data),
    .o_WrAdv(wr_adv), .o_RdData(rd_data), .o_RdValid(rd_valid),
    .o_Done(done), .o_Error(error), .o_N_CS(n_cs), .o_N_DS(n_ds),
    .o_R_NW(r_nw), .o_AddrBus(addr_bus), .o_DataOut(data_out),
    .o_DataOutEn(data_en), .i_DataIn(data_in), .i_N_Wait(n_wait)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0]  mem [0:255];
  logic [7:0]  exp_rd [$];
  logic [15:0] exp_wr [$];
  logic [7:0]  obs_rd [$];
  logic [15:0] obs_wr [$];
  logic [7:0]  wr_q [$];
  int          wr_idx;

  int done_cnt, err_cnt, done_cycle, rdv_cycle;
  int ncs_first, ncs_last, ncs_low, nds_first, nds_low;
  int bus_bad, wradv_cnt, tmo;
  int wait_len = 0;
  bit wait_forever = 1'b0;
  int inject_n = -1;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Runs one transaction from its accept cycle (cycle 0) to Done, acting as
  // the DSP and the write-data source, and records what the bus did.
  task automatic watch(input int budget);
    logic prev_nds;
    int   s;
    done_cnt = 0; err_cnt = 0; done_cycle = -1; rdv_cycle = -1;
    ncs_first = -1; ncs_last = -1; ncs_low = 0; nds_first = -1; nds_low = 0;
    bus_bad = 0; wradv_cnt = 0; tmo = 1;
    obs_rd.delete(); obs_wr.delete();
    prev_nds = n_ds;
    s = 0;
    for (int n = 0; n <= budget; n++) begin
      if (n > 0) begin
        step();
        if (n == inject_n) begin
          start = 1'b1; write = 1'b0; addr = 8'h77; len = 4'd0;
        end else begin
          start = 1'b0;
        end
        if (!n_cs) begin
          if (ncs_first < 0) ncs_first = n;
          ncs_last = n;
          ncs_low++;
        end
        if (!n_ds) begin
          if (nds_first < 0) nds_first = n;
          nds_low++;
          s = prev_nds ? 1 : s + 1;
          if (data_en !== !r_nw) bus_bad++;
          if (!r_nw) begin
            if (prev_nds) obs_wr.push_back({addr_bus, data_out});
            else if (obs_wr.size() == 0 || obs_wr[$] !== {addr_bus, data_out}) bus_bad++;
          end
        end else begin
          s = 0;
        end
        prev_nds = n_ds;
        if (rd_valid) begin
          obs_rd.push_back(rd_data);
          rdv_cycle = n;
        end
        if (done) begin
          done_cnt++;
          done_cycle = n;
          if (error) err_cnt++;
          tmo = 0;
          break;
        end
      end
      wr_data = (wr_idx < wr_q.size()) ? wr_q[wr_idx] : 8'hC3;
      n_wait  = !((!n_ds) && (wait_forever || s <= wait_len));
      data_in = (!n_ds && n_wait) ? mem[addr_bus] : 8'hEE;
      #1;
      if (wr_adv) begin
        wradv_cnt++;
        wr_idx++;
      end
    end
    n_wait  = 1'b1;
    data_in = 8'hEE;
  endtask

  task automatic test_reset();
    n_reset = 1'b0; start = 1'b1; write = 1'b1; wr_data = 8'h99;
    step(); step();
    #1;
    checks++; if (wr_adv !== 1'b0) begin failures++; $display("FAIL reset_wradv: got %b expected 0", wr_adv); end
    n_reset = 1'b1; start = 1'b0; write = 1'b0;
    step();
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", ready); end
    checks++; if ({n_cs, n_ds, r_nw} !== 3'b111) begin failures++; $display("FAIL reset_strobes: got %b expected 111", {n_cs, n_ds, r_nw}); end
    checks++; if (data_en !== 1'b0) begin failures++; $display("FAIL reset_dataen: got %b expected 0", data_en); end
    checks++; if ({addr_bus, data_out, rd_data} !== 24'h0) begin failures++; $display("FAIL reset_buses: got %h expected 000000", {addr_bus, data_out, rd_data}); end
    checks++; if ({wr_adv, rd_valid, done, error} !== 4'b0) begin failures++; $display("FAIL reset_pulses: got %b expected 0000", {wr_adv, rd_valid, done, error}); end
  endtask

  task automatic test_single_read();
    logic [7:0] e;
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL rd1_ready: got %b expected 1", ready); end
    exp_rd.push_back(8'hA5);
    start = 1'b1; write = 1'b0; addr = 8'h3C; len = 4'd0; wait_len = 0;
    watch(40);
    checks++; if (tmo !== 0) begin failures++; $display("FAIL rd1_timeout: got %0d expected 0", tmo); end
    checks++; if (done_cycle !== 5) begin failures++; $display("FAIL rd1_done_cycle: got %0d expected 5", done_cycle); end
    checks++; if ({ncs_first, ncs_last} !== {32'sd1, 32'sd4}) begin failures++; $display("FAIL rd1_ncs: got %0d..%0d expected 1..4", ncs_first, ncs_last); end
    checks++; if ({nds_first, nds_low} !== {32'sd2, 32'sd2}) begin failures++; $display("FAIL rd1_nds: got first %0d count %0d expected 2 2", nds_first, nds_low); end
    checks++; if (rdv_cycle !== 4) begin failures++; $display("FAIL rd1_rdvalid_cycle: got %0d expected 4", rdv_cycle); end
    checks++; if ({err_cnt, wradv_cnt, bus_bad} !== 96'h0) begin failures++; $display("FAIL rd1_misc: got err %0d wradv %0d bad %0d expected 0 0 0", err_cnt, wradv_cnt, bus_bad); end
    while (exp_rd.size() > 0) begin
      e = exp_rd.pop_front();
      checks++;
      if (obs_rd.size() == 0) begin failures++; $display("FAIL rd1_data: got none expected %h", e); end
      else if (obs_rd[0] !== e) begin failures++; $display("FAIL rd1_data: got %h expected %h", obs_rd.pop_front(), e); end
      else void'(obs_rd.pop_front());
    end
    checks++; if (obs_rd.size() !== 0) begin failures++; $display("FAIL rd1_extra: got %0d extra words expected 0", obs_rd.size()); end
  endtask

  task automatic test_write_burst();
    logic [15:0] e;
    wr_q.delete();
    wr_q.push_back(8'h11); wr_q.push_back(8'h22); wr_q.push_back(8'h33);
    wr_idx = 0;
    exp_wr.push_back(16'hFE11); exp_wr.push_back(16'hFF22); exp_wr.push_back(16'h0033);
    inject_n = 3;
    start = 1'b1; write = 1'b1; addr = 8'hFE; len = 4'd2; wr_data = 8'h11;
    watch(60);
    inject_n = -1;
    checks++; if (tmo !== 0) begin failures++; $display("FAIL wr_timeout: got %0d expected 0", tmo); end
    checks++; if (done_cycle !== 13) begin failures++; $display("FAIL wr_done_cycle: got %0d expected 13", done_cycle); end
    checks++; if ({ncs_first, ncs_last, ncs_low} !== {32'sd1, 32'sd12, 32'sd12}) begin failures++; $display("FAIL wr_ncs_continuous: got %0d..%0d low %0d expected 1..12 low 12", ncs_first, ncs_last, ncs_low); end
    checks++; if (wradv_cnt !== 3) begin failures++; $display("FAIL wr_wradv_count: got %0d expected 3", wradv_cnt); end
    checks++; if (bus_bad !== 0) begin failures++; $display("FAIL wr_bus_stable: got %0d bad strobe cycles expected 0", bus_bad); end
    checks++; if ({done_cnt, err_cnt} !== {32'sd1, 32'sd0}) begin failures++; $display("FAIL wr_done_err: got %0d %0d expected 1 0", done_cnt, err_cnt); end
    while (exp_wr.size() > 0) begin
      e = exp_wr.pop_front();
      checks++;
      if (obs_wr.size() == 0) begin failures++; $display("FAIL wr_word: got none expected addr/data %h", e); end
      else if (obs_wr[0] !== e) begin failures++; $display("FAIL wr_word: got addr/data %h expected %h", obs_wr.pop_front(), e); end
      else void'(obs_wr.pop_front());
    end
    checks++; if (obs_wr.size() !== 0) begin failures++; $display("FAIL wr_extra: got %0d extra words expected 0", obs_wr.size()); end
    step();
    checks++; if ({n_cs, ready} !== 2'b11) begin failures++; $display("FAIL wr_ignored_start: got ncs/ready %b expected 11", {n_cs, ready}); end
  endtask

  task automatic test_read_burst_wrap();
    logic [7:0] a;
    logic [7:0] e;
    for (int i = 0; i < 4; i++) begin
      a = 8'hFD + 8'(i);
      exp_rd.push_back(mem[a]);
    end
    start = 1'b1; write = 1'b0; addr = 8'hFD; len = 4'd3;
    watch(60);
    checks++; if (done_cycle !== 17) begin failures++; $display("FAIL rdb_done_cycle: got %0d expected 17", done_cycle); end
    checks++; if (ncs_low !== 16) begin failures++; $display("FAIL rdb_ncs_low: got %0d expected 16", ncs_low); end
    while (exp_rd.size() > 0) begin
      e = exp_rd.pop_front();
      checks++;
      if (obs_rd.size() == 0) begin failures++; $display("FAIL rdb_data: got none expected %h", e); end
      else if (obs_rd[0] !== e) begin failures++; $display("FAIL rdb_data: got %h expected %h", obs_rd.pop_front(), e); end
      else void'(obs_rd.pop_front());
    end
    checks++; if (obs_rd.size() !== 0) begin failures++; $display("FAIL rdb_extra: got %0d extra expected 0", obs_rd.size()); end
  endtask

  task automatic test_wait_ext();
    logic [7:0] e;
    exp_rd.push_back(mem[8'h10]);
    wait_len = 3;
    start = 1'b1; write = 1'b0; addr = 8'h10; len = 4'd0;
    watch(40);
    wait_len = 0;
    checks++; if (nds_low !== 4) begin failures++; $display("FAIL wait_nds_low: got %0d expected 4", nds_low); end
    checks++; if ({rdv_cycle, done_cycle} !== {32'sd6, 32'sd7}) begin failures++; $display("FAIL wait_timing: got rdvalid %0d done %0d expected 6 7", rdv_cycle, done_cycle); end
    checks++; if (err_cnt !== 0) begin failures++; $display("FAIL wait_error: got %0d expected 0", err_cnt); end
    e = exp_rd.pop_front();
    checks++;
    if (obs_rd.size() != 1 || obs_rd[0] !== e) begin failures++; $display("FAIL wait_data: got %0d words first %h expected 1 word %h", obs_rd.size(), (obs_rd.size() > 0) ? obs_rd[0] : 8'hxx, e); end
  endtask

  task automatic test_timeout();
    wait_forever = 1'b1;
    start = 1'b1; write = 1'b0; addr = 8'h20; len = 4'd3;
    watch(60);
    wait_forever = 1'b0;
    checks++; if (tmo !== 0) begin failures++; $display("FAIL tmo_no_done: got %0d expected 0", tmo); end
    checks++; if ({done_cycle, nds_low} !== {32'sd19, 32'sd17}) begin failures++; $display("FAIL tmo_timing: got done %0d strobe %0d expected 19 17", done_cycle, nds_low); end
    checks++; if (err_cnt !== 1) begin failures++; $display("FAIL tmo_error: got %0d expected 1", err_cnt); end
    checks++; if ({n_cs, n_ds, ready} !== 3'b111) begin failures++; $display("FAIL tmo_bus_idle: got %b expected 111", {n_cs, n_ds, ready}); end
    checks++; if (obs_rd.size() !== 0) begin failures++; $display("FAIL tmo_rdvalid: got %0d words expected 0", obs_rd.size()); end
    step();
    checks++; if ({done, error} !== 2'b00) begin failures++; $display("FAIL tmo_pulse_len: got %b expected 00", {done, error}); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e;
    exp_rd.push_back(mem[8'h3C]);
    start = 1'b1; write = 1'b0; addr = 8'h3C; len = 4'd0;
    watch(40);
    e = exp_rd.pop_front();
    checks++; if (obs_rd.size() != 1 || obs_rd[0] !== e) begin failures++; $display("FAIL b2b_first_data: got %0d words expected 1 word %h", obs_rd.size(), e); end
    checks++; if ({done, ready} !== 2'b11) begin failures++; $display("FAIL b2b_done_ready: got %b expected 11", {done, ready}); end
    exp_rd.push_back(mem[8'h55]);
    start = 1'b1; write = 1'b0; addr = 8'h55; len = 4'd0;
    watch(40);
    checks++; if (done_cycle !== 5) begin failures++; $display("FAIL b2b_second_done: got %0d expected 5", done_cycle); end
    e = exp_rd.pop_front();
    checks++; if (obs_rd.size() != 1 || obs_rd[0] !== e) begin failures++; $display("FAIL b2b_second_data: got %0d words expected 1 word %h", obs_rd.size(), e); end
  endtask

  task automatic test_reset_mid();
    int seen;
    start = 1'b1; write = 1'b0; addr = 8'h40; len = 4'd2;
    n_wait = 1'b1; data_in = 8'hEE;
    step();
    start = 1'b0;
    step();
    checks++; if (n_ds !== 1'b0) begin failures++; $display("FAIL rst_mid_in_strobe: got nds %b expected 0", n_ds); end
    n_reset = 1'b0;
    step();
    checks++; if ({n_cs, n_ds, r_nw, data_en, ready} !== 5'b11101) begin failures++; $display("FAIL rst_mid_bus: got %b expected 11101", {n_cs, n_ds, r_nw, data_en, ready}); end
    checks++; if ({done, error, rd_valid, addr_bus} !== 11'h0) begin failures++; $display("FAIL rst_mid_outputs: got %h expected 000", {done, error, rd_valid, addr_bus}); end
    n_reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (done || rd_valid || !n_cs) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL rst_mid_no_completion: got %0d active cycles expected 0", seen); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 13 + 7);
    mem[8'h3C] = 8'hA5;
    n_reset = 1'b0; start = 1'b0; write = 1'b0; addr = 8'h00; len = 4'd0;
    wr_data = 8'h00; data_in = 8'hEE; n_wait = 1'b1; wr_idx = 0;
    @(negedge clk);
    test_reset();
    test_single_read();
    test_write_burst();
    test_read_burst_wrap();
    test_wait_ext();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish by 200000 time units");
    $fatal(1);
  end

endmodule
